// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
// Shared definitions for the Bulls & Cows game core.
//   - Default parameter values for bulls_cows_core
//   - FSM state enumeration (also driven out on state_o)
//   - Seven-segment glyph constants for a display front end, with a
//     small lookup helper for numeric digits
// Segment encoding is active-high {g,f,e,d,c,b,a}.
// ---------------------------------------------------------------------------
package bc_pkg;

  // Default build parameters for the core
  localparam int         BC_DEF_DIGITS = 3;
  localparam int         BC_DEF_DW     = 3;
  localparam int         BC_DEF_LIVES  = 10;
  localparam logic [7:0] BC_DEF_SEED   = 8'hA5;

  // Game FSM states; the numeric values are visible on state_o
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_PLAY  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } bc_state_e;

  // Seven-segment glyphs
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_A    = 7'h77;
  localparam logic [6:0] SEG_C    = 7'h39;
  localparam logic [6:0] SEG_F    = 7'h71;
  localparam logic [6:0] SEG_L    = 7'h38;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Maps a numeric value to its glyph; anything above 9 shows a dash
  function automatic logic [6:0] bc_digit_glyph(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bc_lfsr.sv
// ---------------------------------------------------------------------------
// bc_lfsr
// 8-bit maximal-length Galois LFSR (x^8 + x^6 + x^5 + x^4 + 1, right-shift
// toggle mask 8'hB8) with enable and synchronous load.
// Ports:
//   i_clk      - clock, rising edge
//   i_en       - advance one step when high
//   i_load     - synchronous load of i_load_val (wins over i_en)
//   i_load_val - value loaded; must be non-zero to keep the sequence alive
//   o_value    - low OUT_W bits of the register
// ---------------------------------------------------------------------------
module bc_lfsr #(
  parameter int OUT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [7:0]       i_load_val,
  output logic [OUT_W-1:0] o_value
);

  logic [7:0] r_state;

  // Shift right; the bit falling out of position 0 folds back through the
  // tap mask, which walks all 255 non-zero states before repeating.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_state <= i_load_val;
    end else if (i_en) begin
      r_state <= {1'b0, r_state[7:1]} ^ (r_state[0] ? 8'hB8 : 8'h00);
    end
  end

  assign o_value = r_state[OUT_W-1:0];

endmodule

// File: rtl/bulls_cows_core.sv
// ---------------------------------------------------------------------------
// bulls_cows_core
// Bulls & Cows game engine. A secret of DIGITS digits is either drawn from
// a free-running LFSR (new_game) or loaded from secret_in (load_secret).
// Each accepted guess is scored one position per cycle: a_cnt counts exact
// matches, b_cnt counts digits present in the secret at another position.
// Optional build macro: BC_DUP_CHECK_EN rejects guesses with a repeated
// digit (invalid pulse, no scoring); without it invalid is tied to 0.
// Ports:
//   clk          - clock, all logic on the rising edge
//   rst          - synchronous active-low reset
//   guess        - guess digits, digit i at [i*DW +: DW]
//   submit       - level, rising edge submits guess (PLAY only)
//   new_game     - level, rising edge starts secret generation
//   load_secret  - loads secret_in while IDLE or PLAY
//   secret_in    - externally supplied secret
//   a_cnt/b_cnt  - last score (bulls / cows)
//   lives        - remaining guesses
//   result_valid - one-cycle pulse when a_cnt/b_cnt update
//   invalid      - one-cycle pulse when a guess is rejected
//   state_o      - current FSM state encoding
// ---------------------------------------------------------------------------
module bulls_cows_core
  import bc_pkg::*;
#(
  parameter int         DIGITS = BC_DEF_DIGITS,
  parameter int         DW     = BC_DEF_DW,
  parameter int         LIVES  = BC_DEF_LIVES,
  parameter logic [7:0] SEED   = BC_DEF_SEED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIGITS*DW-1:0]         guess,
  input  logic                         submit,
  input  logic                         new_game,
  input  logic                         load_secret,
  input  logic [DIGITS*DW-1:0]         secret_in,
  output logic [$clog2(DIGITS+1)-1:0]  a_cnt,
  output logic [$clog2(DIGITS+1)-1:0]  b_cnt,
  output logic [3:0]                   lives,
  output logic                         result_valid,
  output logic                         invalid,
  output logic [2:0]                   state_o
);

  localparam int              CW       = $clog2(DIGITS + 1);
  localparam int              VW       = DIGITS * DW;
  localparam logic [CW-1:0]   DIGITS_C = CW'(DIGITS);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);
  localparam logic [3:0]      LIVES_C  = 4'(LIVES);

  // Parameter sanity: the draw loop in GEN can only finish if there are at
  // least DIGITS distinct DW-bit values, and the LFSR only has 8 bits.
  generate
    if ((2 ** DW) < DIGITS) begin : g_bad_dw
      $error("bulls_cows_core: 2**DW must be >= DIGITS");
    end
    if (DW > 8) begin : g_bad_dw_wide
      $error("bulls_cows_core: DW must not exceed the 8-bit LFSR");
    end
    if ((DIGITS < 2) || (DIGITS > 8)) begin : g_bad_digits
      $error("bulls_cows_core: DIGITS must be 2..8");
    end
    if ((LIVES < 1) || (LIVES > 15)) begin : g_bad_lives
      $error("bulls_cows_core: LIVES must be 1..15");
    end
    if (SEED == 8'h00) begin : g_bad_seed
      $error("bulls_cows_core: SEED must be non-zero");
    end
  endgenerate

  bc_state_e       r_state;
  bc_state_e       w_stateNext;

  logic            r_submitDly;
  logic            r_newGameDly;
  logic [VW-1:0]   r_secret;
  logic [VW-1:0]   r_guess;
  logic [CW-1:0]   r_genCnt;
  logic [CW-1:0]   r_idx;
  logic [CW-1:0]   r_accA;
  logic [CW-1:0]   r_accB;
  logic [CW-1:0]   r_aCnt;
  logic [CW-1:0]   r_bCnt;
  logic [3:0]      r_lives;
  logic            r_resultValid;

  logic            w_subRise;
  logic            w_ngRise;
  logic [DW-1:0]   w_draw;
  logic            w_drawDup;
  logic [DW-1:0]   w_gCur;
  logic [DW-1:0]   w_sCur;
  logic            w_inSecret;
  logic            w_hitA;
  logic            w_hitB;
  logic            w_win;
  logic [3:0]      w_livesDec;

  logic            w_enterGen;
  logic            w_load;
  logic            w_accept;
  logic            w_genTake;
  logic            w_eval;
  logic            w_commit;

  // The LFSR runs every cycle regardless of state, so when the player
  // presses new_game decides which digits get drawn. Reset reloads SEED.
  bc_lfsr #(
    .OUT_W (DW)
  ) u_lfsr (
    .i_clk      (clk),
    .i_en       (1'b1),
    .i_load     (~rst),
    .i_load_val (SEED),
    .o_value    (w_draw)
  );

  assign w_subRise = submit & ~r_submitDly;
  assign w_ngRise  = new_game & ~r_newGameDly;

  // While generating, a drawn digit is only kept if it differs from every
  // digit already accepted (slots below r_genCnt).
  always_comb begin
    w_drawDup = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((CW'(k) < r_genCnt) && (r_secret[k*DW +: DW] == w_draw)) begin
        w_drawDup = 1'b1;
      end
    end
  end

  // Scoring datapath for the position selected by r_idx. A cow is a digit
  // that misses its own position but appears somewhere in the secret; since
  // it already differs from its own slot, any match found is at j != i.
  always_comb begin
    w_gCur     = '0;
    w_sCur     = '0;
    w_inSecret = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == CW'(k)) begin
        w_gCur = r_guess[k*DW +: DW];
        w_sCur = r_secret[k*DW +: DW];
      end
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (r_secret[k*DW +: DW] == w_gCur) begin
        w_inSecret = 1'b1;
      end
    end
    w_hitA = (w_gCur == w_sCur);
    w_hitB = ~w_hitA & w_inSecret;
  end

  assign w_win      = (r_accA == DIGITS_C);
  assign w_livesDec = (r_lives == 4'd0) ? 4'd0 : (r_lives - 4'd1);

`ifdef BC_DUP_CHECK_EN
  logic w_guessDup;
  logic w_reject;
  logic r_invalid;

  // Any pair of equal digits in the live guess input makes it illegal.
  always_comb begin
    w_guessDup = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      for (int j = i + 1; j < DIGITS; j++) begin
        if (guess[i*DW +: DW] == guess[j*DW +: DW]) begin
          w_guessDup = 1'b1;
        end
      end
    end
  end

  // Rejection pulse is registered so it appears the cycle after the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_invalid <= 1'b0;
    end else begin
      r_invalid <= w_reject;
    end
  end

  assign invalid = r_invalid;
`else
  assign invalid = 1'b0;
`endif

  // FSM next-state and control strobes. A new_game edge outranks
  // everything; load_secret outranks submit in PLAY. CHECK spends DIGITS
  // cycles scoring and one more cycle publishing the result.
  always_comb begin
    w_stateNext = r_state;
    w_enterGen  = 1'b0;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_genTake   = 1'b0;
    w_eval      = 1'b0;
    w_commit    = 1'b0;
`ifdef BC_DUP_CHECK_EN
    w_reject    = 1'b0;
`endif
    if (w_ngRise) begin
      w_enterGen  = 1'b1;
      w_stateNext = ST_GEN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_secret) begin
            w_load      = 1'b1;
            w_stateNext = ST_PLAY;
          end
        end
        ST_GEN: begin
          if (!w_drawDup) begin
            w_genTake = 1'b1;
            if (r_genCnt == (DIGITS_C - ONE_C)) begin
              w_stateNext = ST_PLAY;
            end
          end
        end
        ST_PLAY: begin
          if (load_secret) begin
            w_load = 1'b1;
          end else if (w_subRise) begin
`ifdef BC_DUP_CHECK_EN
            if (w_guessDup) begin
              w_reject = 1'b1;
            end else begin
              w_accept    = 1'b1;
              w_stateNext = ST_CHECK;
            end
`else
            w_accept    = 1'b1;
            w_stateNext = ST_CHECK;
`endif
          end
        end
        ST_CHECK: begin
          if (r_idx == DIGITS_C) begin
            w_commit = 1'b1;
            if (w_win) begin
              w_stateNext = ST_WIN;
            end else if (w_livesDec == 4'd0) begin
              w_stateNext = ST_LOSE;
            end else begin
              w_stateNext = ST_PLAY;
            end
          end else begin
            w_eval = 1'b1;
          end
        end
        default: begin
          w_stateNext = r_state;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Datapath registers: edge detectors, secret, sampled guess, scoring
  // accumulators, published score and lives. The strobes from the FSM
  // are mutually exclusive, so the order of the ifs below is immaterial.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_submitDly   <= 1'b0;
      r_newGameDly  <= 1'b0;
      r_secret      <= '0;
      r_guess       <= '0;
      r_genCnt      <= '0;
      r_idx         <= '0;
      r_accA        <= '0;
      r_accB        <= '0;
      r_aCnt        <= '0;
      r_bCnt        <= '0;
      r_lives       <= LIVES_C;
      r_resultValid <= 1'b0;
    end else begin
      r_submitDly   <= submit;
      r_newGameDly  <= new_game;
      r_resultValid <= 1'b0;
      if (w_enterGen) begin
        r_lives  <= LIVES_C;
        r_aCnt   <= '0;
        r_bCnt   <= '0;
        r_genCnt <= '0;
      end
      if (w_load) begin
        r_secret <= secret_in;
        r_lives  <= LIVES_C;
      end
      if (w_genTake) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (r_genCnt == CW'(k)) begin
            r_secret[k*DW +: DW] <= w_draw;
          end
        end
        r_genCnt <= r_genCnt + ONE_C;
      end
      if (w_accept) begin
        r_guess <= guess;
        r_idx   <= '0;
        r_accA  <= '0;
        r_accB  <= '0;
      end
      if (w_eval) begin
        r_accA <= r_accA + CW'(w_hitA);
        r_accB <= r_accB + CW'(w_hitB);
        r_idx  <= r_idx + ONE_C;
      end
      if (w_commit) begin
        r_aCnt        <= r_accA;
        r_bCnt        <= r_accB;
        r_resultValid <= 1'b1;
        if (!w_win) begin
          r_lives <= w_livesDec;
        end
      end
    end
  end

  assign a_cnt        = r_aCnt;
  assign b_cnt        = r_bCnt;
  assign lives        = r_lives;
  assign result_valid = r_resultValid;
  assign state_o      = r_state;

endmodule
